sdram_slot_arbiter: RTL and testbench
=====================================

Name: sdram_slot_arbiter

Overview:
- Shares the 8 MHz slot-based SDRAM controller between three requesters: flash loader (port 0), video fetch (port 1) and CPU (port 2).
- Each slot runs from one sync strobe to the next. The arbiter grants at most one requester per slot and drives the controller's we/oe/addr/din/ds for that slot.
- At the end of the slot it returns read data and an ack to the requester.
- Sits between the requesters and the sdram module. Runs entirely on the 64 MHz clk.

Parameters:
- AW, 20, word address width on all ports.
- DW, 16, data width.
- REFRESH_PERIOD, 64, slots between forced refresh slots (used only with the optional feature).

Ports:
- clk  in  1  64 MHz system clock.
- reset  in  1  synchronous, active-high.
- sync  in  1  one-clk strobe marking a slot boundary, every 8 clk.
- req  in  3  per-port request; held high until ack.
- req_we  in  3  per-port write (1) / read (0); stable while req is high.
- req_addr  in  3*AW  per-port word address, port n at [n*AW +: AW].
- req_wdata  in  3*DW  per-port write data.
- req_ds  in  6  per-port byte strobes, 2 bits per port.
- ack  out  3  one-clk pulse per port on slot completion.
- rdata  out  DW  read data; valid on the ack clk; shared by all ports.
- mem_we  out  1  to controller we.
- mem_oe  out  1  to controller oe.
- mem_addr  out  AW  to controller addr.
- mem_din  out  DW  to controller din.
- mem_ds  out  2  to controller ds.
- mem_dout  in  DW  from controller dout; valid at the sync ending a read slot.
- busy  out  1  high while a slot is granted.

Behaviour:
- Reset:
  - All outputs 0; grant is none; round-robin pointer selects port 1; slot counter 0.
  - A reset mid-slot abandons the slot: no ack is issued and the mem_* outputs drop on the next clk.
- Slot FSM, two states: IDLE (no grant) and ACTIVE (grant g in 0..2).
  - All transitions happen only on clk with sync=1.
  - On sync with state ACTIVE: pulse ack[g] for that clk. If the slot was a read, latch rdata <= mem_dout on the same clk. Write slots leave rdata unchanged.
  - On the same sync, arbitrate among eligible requests, where eligible = req & ~ack_now.
    - The port being acked is never re-granted on that sync; it must drop req or is considered on the following sync.
- Priority:
  - Port 0 is strictly highest.
  - Ports 1 and 2 round-robin. After port 1 or 2 is granted, the pointer moves to the other port. Port 0 grants do not move the pointer.
- On grant:
  - The next state is ACTIVE(g). On the following clk, mem_addr, mem_din, mem_ds and mem_we = req_we[g] are registered from port g.
  - mem_oe = ~req_we[g]. busy = 1.
  - Held constant until the next sync.
- With no eligible request: next state is IDLE, with mem_we = mem_oe = 0 and busy = 0. The controller refreshes in such slots.
- Latency:
  - A request present at sync S is acked at sync S+1, i.e. 8 clk later.
  - A request arriving between syncs waits for the next sync, so the worst case with no contention is 15 clk.
- Port 0 continuously requesting starves ports 1 and 2. This is by design: the loader owns memory until it is done.
- Changing req_* while req is high and ungranted is allowed. The values sampled are those on the granting sync.
- ack and rdata are registered outputs. No combinational path from req to any output.

Optional Feature:
- Macro: SDRAM_ARB_REFRESH_SLOT_EN.
- When defined:
  - A slot counter increments every sync and wraps at REFRESH_PERIOD-1.
  - The slot beginning on the sync where the counter equals REFRESH_PERIOD-1 is forced IDLE regardless of requests, guaranteeing refresh.
  - Pending requests wait. An ack due on that sync is still issued.
- When undefined: there is no counter and slots are never forced idle.

Decomposition:
- Shared package sdram_arb_pkg:
  - Port index constants PORT_LOADER=0, PORT_VIDEO=1, PORT_CPU=2.
  - Grant encoding typedef (NONE plus the three indices).
  - Default AW/DW.
- One natural sub-module, rr_prio_pick: combinational fixed-priority-plus-round-robin picker. It takes the eligible vector and pointer and returns the grant.

Test Plan:
- Port 2 reads addr 0x00123 alone at sync S, with mem_dout=0xBEEF at S+1 -> mem_oe=1 and mem_addr=0x00123 during the slot; ack=3'b100 and rdata=0xBEEF on S+1; mem_we stays 0.
- Port 0 writes 0xA5A5 to 0x00010 with ds=2'b01, simultaneous with a port 2 read -> port 0 is granted first with mem_we=1, mem_din=0xA5A5, mem_ds=01; port 2 is granted at the next sync.
- Ports 1 and 2 request continuously for 6 slots -> grants alternate 1,2,1,2,1,2 and each ack lands one sync after its grant.
- Port 1 acked at sync S with req still high that clk -> port 1 is not granted at S; it is granted at S+1 if still requesting and the slot at S is otherwise IDLE.
- Reset asserted 3 clk into an ACTIVE read slot -> no ack; mem_oe=0 next clk; after release, the first grant waits for a sync.
- With SDRAM_ARB_REFRESH_SLOT_EN and REFRESH_PERIOD=4, port 2 requesting continuously -> every 4th slot has mem_we=mem_oe=0 and busy=0; the other slots are granted.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM slot arbiter: port indices, grant and
// slot-state encodings, default widths and a grant-to-one-hot helper.
package sdram_arb_pkg;

    localparam int PORT_LOADER = 0;
    localparam int PORT_VIDEO  = 1;
    localparam int PORT_CPU    = 2;
    localparam int NUM_PORTS   = 3;

    localparam int DEFAULT_AW = 20;
    localparam int DEFAULT_DW = 16;

    typedef enum logic [1:0] {
        GNT_LOADER = 2'd0,
        GNT_VIDEO  = 2'd1,
        GNT_CPU    = 2'd2,
        GNT_NONE   = 2'd3
    } grant_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } slot_state_e;

    function automatic logic [NUM_PORTS-1:0] grant_onehot(input grant_e g);
        case (g)
            GNT_LOADER: return 3'b001;
            GNT_VIDEO:  return 3'b010;
            GNT_CPU:    return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/sdram_slot_arbiter_rr_prio_pick.sv
// Combinational grant picker: loader port wins outright, video and CPU
// share the remaining slots round-robin according to ptr_cpu.
module rr_prio_pick
    import sdram_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] elig,
    input  logic                 ptr_cpu,
    output grant_e               grant
);

    always_comb begin
        grant = GNT_NONE;
        if (elig[PORT_LOADER]) begin
            grant = GNT_LOADER;
        end else if (elig[PORT_VIDEO] && elig[PORT_CPU]) begin
            grant = ptr_cpu ? GNT_CPU : GNT_VIDEO;
        end else if (elig[PORT_VIDEO]) begin
            grant = GNT_VIDEO;
        end else if (elig[PORT_CPU]) begin
            grant = GNT_CPU;
        end
    end

endmodule

// File: rtl/sdram_slot_arbiter.sv
// Slot arbiter sharing the 8 MHz slot SDRAM controller between loader, video
// and CPU. Optional forced refresh slots: define SDRAM_ARB_REFRESH_SLOT_EN.
module sdram_slot_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int AW             = DEFAULT_AW,
    parameter int DW             = DEFAULT_DW,
    parameter int REFRESH_PERIOD = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sync,
    input  logic [NUM_PORTS-1:0]   req,
    input  logic [NUM_PORTS-1:0]   req_we,
    input  logic [NUM_PORTS*AW-1:0] req_addr,
    input  logic [NUM_PORTS*DW-1:0] req_wdata,
    input  logic [NUM_PORTS*2-1:0] req_ds,
    output logic [NUM_PORTS-1:0]   ack,
    output logic [DW-1:0]          rdata,
    output logic                   mem_we,
    output logic                   mem_oe,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_din,
    output logic [1:0]             mem_ds,
    input  logic [DW-1:0]          mem_dout,
    output logic                   busy
);

    slot_state_e          state_q, state_d;
    grant_e               grant_q, grant_d;
    logic                 ptr_cpu_q, ptr_cpu_d;
    logic [NUM_PORTS-1:0] ack_q, ack_d;
    logic [DW-1:0]        rdata_q, rdata_d;
    logic                 mem_we_q, mem_we_d;
    logic                 mem_oe_q, mem_oe_d;
    logic [AW-1:0]        mem_addr_q, mem_addr_d;
    logic [DW-1:0]        mem_din_q, mem_din_d;
    logic [1:0]           mem_ds_q, mem_ds_d;
    logic                 busy_q, busy_d;

    logic [NUM_PORTS-1:0] ack_now;
    logic [NUM_PORTS-1:0] elig;
    grant_e               pick;
    logic                 force_idle;
    logic                 sel_we;
    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_din;
    logic [1:0]           sel_ds;

    // The port finishing its slot on this sync must not be re-granted on it.
    assign ack_now = (state_q == ST_ACTIVE) ? grant_onehot(grant_q) : '0;
    assign elig    = req & ~ack_now;

    rr_prio_pick u_pick (
        .elig    (elig),
        .ptr_cpu (ptr_cpu_q),
        .grant   (pick)
    );

`ifdef SDRAM_ARB_REFRESH_SLOT_EN
    localparam int CNT_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_PERIOD - 1);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;

    assign force_idle = (slot_cnt_q == CNT_LAST);

    always_comb begin
        slot_cnt_d = slot_cnt_q;
        if (sync) begin
            slot_cnt_d = (slot_cnt_q == CNT_LAST) ? '0 : slot_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
        end
    end
`else
    assign force_idle = 1'b0;
`endif

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        sel_ds   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (int'(pick) == p) begin
                sel_we   = req_we[p];
                sel_addr = req_addr[p*AW +: AW];
                sel_din  = req_wdata[p*DW +: DW];
                sel_ds   = req_ds[p*2 +: 2];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_cpu_d  = ptr_cpu_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        mem_we_d   = mem_we_q;
        mem_oe_d   = mem_oe_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_ds_d   = mem_ds_q;
        busy_d     = busy_q;
        if (sync) begin
            ack_d = ack_now;
            if (state_q == ST_ACTIVE && mem_oe_q) begin
                rdata_d = mem_dout;
            end
            if (pick != GNT_NONE && !force_idle) begin
                state_d    = ST_ACTIVE;
                grant_d    = pick;
                mem_we_d   = sel_we;
                mem_oe_d   = ~sel_we;
                mem_addr_d = sel_addr;
                mem_din_d  = sel_din;
                mem_ds_d   = sel_ds;
                busy_d     = 1'b1;
                // Loader grants leave the video/CPU turn order untouched.
                if (pick == GNT_VIDEO) begin
                    ptr_cpu_d = 1'b1;
                end else if (pick == GNT_CPU) begin
                    ptr_cpu_d = 1'b0;
                end
            end else begin
                state_d    = ST_IDLE;
                grant_d    = GNT_NONE;
                mem_we_d   = 1'b0;
                mem_oe_d   = 1'b0;
                mem_addr_d = '0;
                mem_din_d  = '0;
                mem_ds_d   = '0;
                busy_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= GNT_NONE;
            ptr_cpu_q  <= 1'b0;
            ack_q      <= '0;
            rdata_q    <= '0;
            mem_we_q   <= 1'b0;
            mem_oe_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_ds_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_cpu_q  <= ptr_cpu_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            mem_we_q   <= mem_we_d;
            mem_oe_q   <= mem_oe_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_ds_q   <= mem_ds_d;
            busy_q     <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign mem_we   = mem_we_q;
    assign mem_oe   = mem_oe_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_ds   = mem_ds_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Bench for sdram_slot_arbiter: per-slot behavioural model checked every clk,
// plus directed scenarios with literal expectations.
module tb_sdram_slot_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
`ifdef SDRAM_ARB_REFRESH_SLOT_EN
    localparam int RP         = 4;
    localparam bit REFRESH_ON = 1'b1;
`else
    localparam int RP         = 64;
    localparam bit REFRESH_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            sync;
    logic [2:0]      req;
    logic [2:0]      req_we;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] req_wdata;
    logic [5:0]      req_ds;
    logic [2:0]      ack;
    logic [DW-1:0]   rdata;
    logic            mem_we;
    logic            mem_oe;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_din;
    logic [1:0]      mem_ds;
    logic [DW-1:0]   mem_dout;
    logic            busy;

    int vectors     = 0;
    int miscompares = 0;
    bit keep [3]    = '{0, 0, 0};

    sdram_slot_arbiter #(.AW(AW), .DW(DW), .REFRESH_PERIOD(RP)) dut (
        .clk       (clk),
        .reset     (reset),
        .sync      (sync),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ds    (req_ds),
        .ack       (ack),
        .rdata     (rdata),
        .mem_we    (mem_we),
        .mem_oe    (mem_oe),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_ds    (mem_ds),
        .mem_dout  (mem_dout),
        .busy      (busy)
    );

    // ---------------- clock / sync / reset ----------------
    always #8 clk = ~clk;

    initial begin
        int phase;
        phase = 0;
        sync  = 1'b0;
        forever begin
            @(negedge clk);
            phase = (phase + 1) % 8;
            sync  = (phase == 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want summary before 2 ms");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard check ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (one decision per slot) ----------------
    bit            model_valid = 0;
    int            owner       = -1;
    bit            owner_read  = 0;
    int            last_rr     = 2;
    int            slot_no     = 0;
    logic [2:0]    exp_ack     = '0;
    logic [DW-1:0] exp_rdata   = '0;
    logic          exp_we      = 0;
    logic          exp_oe      = 0;
    logic [AW-1:0] exp_addr    = '0;
    logic [DW-1:0] exp_din     = '0;
    logic [1:0]    exp_ds      = '0;
    logic          exp_busy    = 0;

    task automatic model_step();
        logic [2:0] cand;
        int         nxt;
        bit         forced;
        if (reset === 1'b1) begin
            model_valid = 1;
            owner = -1; owner_read = 0; last_rr = 2; slot_no = 0;
            exp_ack = '0; exp_rdata = '0; exp_we = 0; exp_oe = 0;
            exp_addr = '0; exp_din = '0; exp_ds = '0; exp_busy = 0;
            return;
        end
        exp_ack = '0;
        if (sync !== 1'b1) return;
        cand = req;
        if (owner >= 0) begin
            exp_ack[owner] = 1'b1;
            cand[owner]    = 1'b0;
            if (owner_read) exp_rdata = mem_dout;
        end
        forced  = REFRESH_ON && ((slot_no % RP) == RP - 1);
        slot_no = slot_no + 1;
        nxt     = -1;
        if (!forced) begin
            if (cand[0])                nxt = 0;
            else if (cand[1] && cand[2]) nxt = (last_rr == 1) ? 2 : 1;
            else if (cand[1])           nxt = 1;
            else if (cand[2])           nxt = 2;
        end
        if (nxt == 1 || nxt == 2) last_rr = nxt;
        owner = nxt;
        if (nxt >= 0) begin
            owner_read = !req_we[nxt];
            exp_we   = req_we[nxt];
            exp_oe   = !req_we[nxt];
            exp_addr = req_addr[nxt*AW +: AW];
            exp_din  = req_wdata[nxt*DW +: DW];
            exp_ds   = req_ds[nxt*2 +: 2];
            exp_busy = 1'b1;
        end else begin
            owner_read = 0;
            exp_we = 0; exp_oe = 0; exp_addr = '0; exp_din = '0; exp_ds = '0; exp_busy = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #2;
            if (model_valid) begin
                check("m_ack",   32'(ack),      32'(exp_ack));
                check("m_rdata", 32'(rdata),    32'(exp_rdata));
                check("m_we",    32'(mem_we),   32'(exp_we));
                check("m_oe",    32'(mem_oe),   32'(exp_oe));
                check("m_addr",  32'(mem_addr), 32'(exp_addr));
                check("m_din",   32'(mem_din),  32'(exp_din));
                check("m_ds",    32'(mem_ds),   32'(exp_ds));
                check("m_busy",  32'(busy),     32'(exp_busy));
            end
        end
    end

    // ---------------- requester behaviour: drop req after its ack ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                if (ack[p] === 1'b1 && !keep[p]) req[p] = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int p, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [1:0] ds);
        req_we[p]              = we;
        req_addr[p*AW +: AW]   = addr;
        req_wdata[p*DW +: DW]  = wd;
        req_ds[p*2 +: 2]       = ds;
        req[p]                 = 1'b1;
    endtask

    task automatic next_sync();
        @(posedge clk iff sync);
        #2;
    endtask

    // Leaves the ack clk behind so req updates never race the requester logic.
    task automatic start_window();
        @(posedge clk iff sync);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (req !== 3'b000 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_req", 32'(req), 32'd0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [AW-1:0] exp_seq [6];
        int            idle_cnt;
        exp_seq = '{20'h00111, 20'h00222, 20'h00111, 20'h00222, 20'h00111, 20'h00222};

        reset = 1'b1; req = '0; req_we = '0; req_addr = '0;
        req_wdata = '0; req_ds = '0; mem_dout = '0;
        repeat (4) @(negedge clk);
        check("reset_ack",  32'(ack),  32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Lone CPU read.
        start_window();
        issue(2, 1'b0, 20'h00123, 16'h0000, 2'b11);
        mem_dout = 16'hBEEF;
        next_sync();
        check("rd_oe",   32'(mem_oe),   32'd1);
        check("rd_we",   32'(mem_we),   32'd0);
        check("rd_addr", 32'(mem_addr), 32'h00123);
        next_sync();
        check("rd_ack",   32'(ack),   32'b100);
        check("rd_rdata", 32'(rdata), 32'hBEEF);

        // Loader write beats a simultaneous CPU read.
        start_window();
        issue(0, 1'b1, 20'h00010, 16'hA5A5, 2'b01);
        issue(2, 1'b0, 20'h00200, 16'h0000, 2'b11);
        mem_dout = 16'h1234;
        next_sync();
        check("wr_we",   32'(mem_we),   32'd1);
        check("wr_din",  32'(mem_din),  32'hA5A5);
        check("wr_ds",   32'(mem_ds),   32'b01);
        check("wr_addr", 32'(mem_addr), 32'h00010);
        next_sync();
        check("wr_ack",      32'(ack),      32'b001);
        check("wr_keep_rd",  32'(rdata),    32'hBEEF);
        check("cpu_after",   32'(mem_addr), 32'h00200);
        next_sync();
        check("cpu_ack",   32'(ack),   32'b100);
        check("cpu_rdata", 32'(rdata), 32'h1234);

        // Video and CPU contend continuously.
        start_window();
        keep[1] = 1; keep[2] = 1;
        issue(1, 1'b0, 20'h00111, 16'h0000, 2'b11);
        issue(2, 1'b1, 20'h00222, 16'h5555, 2'b10);
        for (int i = 0; i < 6; i++) begin
            next_sync();
            check("rr_seq", 32'(mem_addr), 32'(exp_seq[i]));
        end
        keep[1] = 0; keep[2] = 0;
        wait_idle();

        // Acked port keeps req high: skipped for one slot, then granted again.
        start_window();
        keep[1] = 1;
        issue(1, 1'b0, 20'h00333, 16'h0000, 2'b11);
        next_sync();
        check("reack_g0", 32'(busy), 32'd1);
        next_sync();
        check("reack_ack",  32'(ack),  32'b010);
        check("reack_idle", 32'(busy), 32'd0);
        next_sync();
        check("reack_g1",   32'(busy),     32'd1);
        check("reack_addr", 32'(mem_addr), 32'h00333);
        keep[1] = 0;
        wait_idle();

        // Reset three clk into an active read slot.
        start_window();
        issue(1, 1'b0, 20'h00ABC, 16'h0000, 2'b11);
        @(posedge clk iff sync);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        req[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("rst_oe",   32'(mem_oe), 32'd0);
        check("rst_busy", 32'(busy),   32'd0);
        issue(2, 1'b0, 20'h00DEF, 16'h0000, 2'b11);
        @(posedge clk);
        #2;
        check("rst_wait", 32'(busy), 32'd0);
        next_sync();
        check("rst_noack", 32'(ack),      32'd0);
        check("rst_grant", 32'(mem_addr), 32'h00DEF);
        wait_idle();

        // Sustained contention: only forced refresh slots may be idle.
        start_window();
        keep[1] = 1; keep[2] = 1;
        issue(1, 1'b0, 20'h00444, 16'h0000, 2'b11);
        issue(2, 1'b0, 20'h00555, 16'h0000, 2'b11);
        idle_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            next_sync();
            if (busy !== 1'b1) idle_cnt++;
        end
        check("refresh_idle", 32'(idle_cnt), REFRESH_ON ? 32'd2 : 32'd0);
        keep[1] = 0; keep[2] = 0;
        wait_idle();
        repeat (2) next_sync();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
